pes_seqdivider: RTL and testbench

- Unsigned iterative restoring divider: inverse operation of the pipelined multiplier, same A/B operand convention.
- Computes Q = A / B and R = A % B, one quotient bit per clock.
- Valid/ready handshake on both sides; sits beside the multiplier in the arithmetic datapath.
- Divide-by-zero is flagged and short-circuited instead of iterated.

---
 rtl/pes_seqdivider.sv | 108 ++++++++++
 tb/tb_pes_seqdivider.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pes_seqdivider.sv
// Unsigned iterative restoring divider: Q = A / B, R = A % B, one quotient bit per clock.
// Valid/ready on both sides; divide-by-zero is flagged and short-circuited.
module pes_seqdivider #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             dz
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] qreg, qreg_nx;
  logic [WIDTH-1:0] rem, rem_nx;
  logic [WIDTH-1:0] breg, breg_nx;
  logic [WIDTH-1:0] q_nx, r_nx;
  logic             dz_nx;
  logic [CNTW-1:0]  cnt, cnt_nx;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      qreg  <= '0;
      rem   <= '0;
      breg  <= '0;
      cnt   <= '0;
      Q     <= '0;
      R     <= '0;
      dz    <= 1'b0;
    end else begin
      state <= state_nx;
      qreg  <= qreg_nx;
      rem   <= rem_nx;
      breg  <= breg_nx;
      cnt   <= cnt_nx;
      Q     <= q_nx;
      R     <= r_nx;
      dz    <= dz_nx;
    end
  end

  // The partial remainder is always below 2^(WIDTH-1) before a shift, so dropping its MSB is safe.
  assign shifted = {1'b0, rem[WIDTH-2:0], qreg[WIDTH-1]};
  assign trial   = shifted - {1'b0, breg};

  always_comb begin
    state_nx = state;
    qreg_nx  = qreg;
    rem_nx   = rem;
    breg_nx  = breg;
    cnt_nx   = cnt;
    q_nx     = Q;
    r_nx     = R;
    dz_nx    = dz;
    case (state)
      IDLE: begin
        if (in_valid) begin
          breg_nx  = B;
          qreg_nx  = A;
          rem_nx   = '0;
          cnt_nx   = CNTW'(WIDTH);
          state_nx = CALC;
        end
      end
      CALC: begin
        // A zero divisor spends exactly one CALC cycle, giving a one-cycle latency.
        if (breg == '0) begin
          q_nx     = '1;
          r_nx     = qreg;
          dz_nx    = 1'b1;
          cnt_nx   = '0;
          state_nx = DONE;
        end else begin
          if (!trial[WIDTH]) rem_nx = trial[WIDTH-1:0];
          else               rem_nx = shifted[WIDTH-1:0];
          qreg_nx = {qreg[WIDTH-2:0], ~trial[WIDTH]};
          cnt_nx  = cnt - CNTW'(1);
          if (cnt == CNTW'(1)) begin
            q_nx     = qreg_nx;
            r_nx     = rem_nx;
            dz_nx    = 1'b0;
            state_nx = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pes_seqdivider.sv
// Scoreboard bench for pes_seqdivider: driver pushes model results, monitor pops on handoff.
module tb_pes_seqdivider;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] Q;
  logic [W-1:0] R;
  logic         dz;

  int           cyc = 0;
  int           acc_cyc = 0;
  int           nchk = 0;
  int           nerr = 0;
  logic [64:0]  exp_q[$];

  pes_seqdivider #(.WIDTH(W), .CNTW(6)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
    .Q(Q), .R(R), .dz(dz)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [64:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    if (b == 0) return {32'hFFFF_FFFF, a, 1'b1};
    return {a / b, a % b, 1'b0};
  endfunction

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] expv);
    nchk++;
    if (act !== expv) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic fail_now(input string name);
    nchk++;
    nerr++;
    $display("FAIL %s: bound expired", name);
  endtask

  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) fail_now("unexpected_result");
      else chk("result", {Q, R, dz}, exp_q.pop_front());
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    int t = 0;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      fail_now("accept_wait");
      return;
    end
    A = a;
    B = b;
    in_valid = 1'b1;
    @(posedge clk);
    exp_q.push_back(model(a, b));
    #1;
    acc_cyc = cyc;
    in_valid = 1'b0;
    A = $urandom;
    B = $urandom;
  endtask

  task automatic wait_done(output int lat, output bit rdy_seen);
    int t = 0;
    rdy_seen = 1'b0;
    lat = -1;
    @(negedge clk);
    while (!out_valid && t < 200) begin
      if (in_ready) rdy_seen = 1'b1;
      @(negedge clk);
      t++;
    end
    if (!out_valid) fail_now("done_wait");
    else lat = cyc - acc_cyc;
  endtask

  logic [W-1:0] b2b_a[3] = '{32'h0000_0A01, 32'h30, 32'h3};
  logic [W-1:0] b2b_b[3] = '{32'h20, 32'h9, 32'h7};
  logic [W-1:0] b2b_q[3] = '{32'h50, 32'h5, 32'h0};
  logic [W-1:0] b2b_r[3] = '{32'h1, 32'h3, 32'h3};

  initial begin
    int lat;
    bit rs;
    bit stable;
    int t;
    logic [W-1:0] ra, rb;

    #3;
    chk("reset_ctl", {out_valid, in_ready, dz}, 3'b010);
    chk("reset_qr", {Q, R}, 64'h0);
    @(negedge clk);
    rst = 1'b1;

    send(32'h0000_3C00, 32'h40);
    wait_done(lat, rs);
    chk("t1_latency", lat, 32);
    chk("t1_qrdz", {Q, R, dz}, {32'hF0, 32'h0, 1'b0});
    @(negedge clk);
    chk("t1_pulse", out_valid, 1'b0);

    for (int i = 0; i < 3; i++) begin
      send(b2b_a[i], b2b_b[i]);
      wait_done(lat, rs);
      chk("b2b_latency", lat, 32);
      chk("b2b_busy_ready", rs, 1'b0);
      chk("b2b_qr", {Q, R}, {b2b_q[i], b2b_r[i]});
    end

    send(32'h0000_1234, 32'h0);
    wait_done(lat, rs);
    chk("dz_latency", lat, 1);
    chk("dz_qrdz", {Q, R, dz}, {32'hFFFF_FFFF, 32'h0000_1234, 1'b1});
    send(32'h10, 32'h3);
    wait_done(lat, rs);
    chk("dz_clear", {Q, R, dz}, {32'h5, 32'h1, 1'b0});

    send(32'hFFFF_FFFF, 32'h1);
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    send(32'h9000, 32'h8000);
    send(32'h0, 32'h1234);
    for (int i = 0; i < 1000; i++) begin
      case ($urandom_range(0, 9))
        0:       rb = 32'h0;
        1, 2:    rb = $urandom_range(1, 255);
        3:       rb = 32'hFFFF_FFFF - $urandom_range(0, 3);
        default: rb = $urandom >> $urandom_range(0, 31);
      endcase
      ra = $urandom >> $urandom_range(0, 8);
      send(ra, rb);
    end
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("random_drain", exp_q.size(), 0);

    out_ready = 1'b0;
    send(32'd123456, 32'd1000);
    wait_done(lat, rs);
    stable = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (!(out_valid && !in_ready && Q == 32'd123 && R == 32'd456 && !dz)) stable = 1'b0;
    end
    chk("bp_stable", stable, 1'b1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_release", {out_valid, in_ready}, 2'b01);

    send(32'h0100_0000, 32'h5);
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("async_reset_ctl", {out_valid, in_ready, dz}, 3'b010);
    chk("async_reset_qr", {Q, R}, 64'h0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    send(32'h64, 32'h7);
    wait_done(lat, rs);
    chk("post_reset_qr", {Q, R, dz}, {32'hE, 32'h2, 1'b0});

    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("sb_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
    $finish;
  end

endmodule
